paged_event_buffer: RTL and testbench

- Multi-page event buffer: a writer fills one page at a time with a variable number of entries, then commits the page together with its entry count; a reader sees committed pages in order, random-reads entries and releases each page for reuse.
- Generalised successor of the single-page/fixed-count memory, adding:
  - parametrised page count and depth
  - writer/reader page ownership with full/empty flow control
  - overflow detection
  - selectable read latency
- Sits between hit/event producers and the downstream readout/formatting logic.

---
 rtl/paged_event_buffer_if.sv | 46 ++++
 rtl/paged_event_buffer.sv | 153 +++++++++++++++
 tb/tb_paged_event_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/paged_event_buffer_if.sv
// Bus bundle for paged_event_buffer: writer beats/commit, reader page view and
// random-access read port.
interface paged_event_buffer_if #(
    parameter int DATA_WIDTH = 18,
    parameter int PAGE_DEPTH = 16,
    parameter int PAGES      = 4
);
    localparam int AW = $clog2(PAGE_DEPTH);
    localparam int PW = $clog2(PAGES);
    localparam int NW = AW + 1;

    // Writer side
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_flush;

    // Reader side
    logic                  rd_page_valid;
    logic [PW-1:0]         rd_page;
    logic [NW-1:0]         rd_nent;
    logic                  rd_ovf;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_dvalid;
    logic                  rd_release;
    logic [PW:0]           pages_used;

    // Producer/consumer logic drives the requests and sees the status
    modport master (
        output wr_valid, wr_data, wr_last, wr_flush,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, rd_page_valid, rd_page, rd_nent, rd_ovf,
        input  rd_data, rd_dvalid, pages_used
    );

    // The buffer itself
    modport slave (
        input  wr_valid, wr_data, wr_last, wr_flush,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, rd_page_valid, rd_page, rd_nent, rd_ovf,
        output rd_data, rd_dvalid, pages_used
    );
endinterface

// File: rtl/paged_event_buffer.sv
// Multi-page event buffer. The writer fills one page at a time and commits it
// with its entry count; the reader walks committed pages in order, reads
// entries at random and releases each page back to the free pool.
module paged_event_buffer #(
    parameter int DATA_WIDTH = 18,
    parameter int PAGE_DEPTH = 16,
    parameter int PAGES      = 4,
    parameter int RD_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    paged_event_buffer_if.slave bus
);
    localparam int AW = $clog2(PAGE_DEPTH);
    localparam int PW = $clog2(PAGES);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] FULL_CNT  = NW'(PAGE_DEPTH);
    localparam logic [PW:0]   MAX_PAGES = (PW+1)'(PAGES);

    logic [DATA_WIDTH-1:0]      mem [PAGES*PAGE_DEPTH];
    logic [PW-1:0]              wr_pg;
    logic [PW-1:0]              rd_pg;
    logic [NW-1:0]              fill_cnt;
    logic                       fill_ovf;
    logic [PAGES-1:0][NW-1:0]   nent;
    logic [PAGES-1:0]           page_ovf;
    logic [PW:0]                pages_used;

    logic                       wr_ready;
    logic                       page_valid;
    logic                       beat_ok;
    logic                       room;
    logic                       store;
    logic                       commit;
    logic                       rel_pg;
    logic [NW-1:0]              fin_cnt;
    logic                       fin_ovf;
    logic [NW-1:0]              cur_nent;
    logic                       rd_take;
    logic                       rd_hit;
    logic [PW+AW-1:0]           wr_idx;
    logic [PW+AW-1:0]           rd_idx;

    logic                       s1_valid;
    logic [DATA_WIDTH-1:0]      s1_data;

    assign wr_ready   = pages_used < MAX_PAGES;
    assign page_valid = pages_used != '0;
    assign beat_ok    = bus.wr_valid && wr_ready;
    assign room       = fill_cnt != FULL_CNT;
    assign store      = beat_ok && room;
    // A flush alongside a beat acts as wr_last: still exactly one commit
    assign commit     = wr_ready && ((bus.wr_valid && bus.wr_last) || bus.wr_flush);
    assign rel_pg     = bus.rd_release && page_valid;
    // Count and overflow the page will hold once this cycle's beat is taken
    assign fin_cnt    = store ? fill_cnt + 1'b1 : fill_cnt;
    assign fin_ovf    = fill_ovf || (beat_ok && !room);
    assign cur_nent   = nent[rd_pg];
    assign rd_take    = bus.rd_en && page_valid;
    assign rd_hit     = {1'b0, bus.rd_addr} < cur_nent;
    assign wr_idx     = {wr_pg, fill_cnt[AW-1:0]};
    assign rd_idx     = {rd_pg, bus.rd_addr};

    // Writer page state: fill count, sticky overflow, per-page commit record
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_pg    <= '0;
            fill_cnt <= '0;
            fill_ovf <= 1'b0;
            nent     <= '0;
            page_ovf <= '0;
        end else if (commit) begin
            nent[wr_pg]     <= fin_cnt;
            page_ovf[wr_pg] <= fin_ovf;
            wr_pg           <= wr_pg + 1'b1;
            fill_cnt        <= '0;
            fill_ovf        <= 1'b0;
        end else begin
            fill_cnt <= fin_cnt;
            fill_ovf <= fin_ovf;
        end
    end

    // Reader pointer and committed-page occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pg      <= '0;
            pages_used <= '0;
        end else begin
            if (rel_pg)
                rd_pg <= rd_pg + 1'b1;
            if (commit && !rel_pg)
                pages_used <= pages_used + 1'b1;
            else if (rel_pg && !commit)
                pages_used <= pages_used - 1'b1;
        end
    end

    // Entry storage; the filling page never equals the reading page
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; pages are only read below their committed count.
        if (store)
            mem[wr_idx] <= bus.wr_data;
    end

    // First read stage: synchronous lookup, zeros beyond the page's count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_take;
            if (rd_take)
                s1_data <= rd_hit ? mem[rd_idx] : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Optional output register for the two-cycle read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                end
            end

            assign bus.rd_dvalid = s2_valid;
            assign bus.rd_data   = s2_data;
        end else begin : g_lat1
            assign bus.rd_dvalid = s1_valid;
            assign bus.rd_data   = s1_data;
        end

        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("paged_event_buffer: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    assign bus.wr_ready      = wr_ready;
    assign bus.rd_page_valid = page_valid;
    assign bus.rd_page       = rd_pg;
    assign bus.rd_nent       = cur_nent;
    assign bus.rd_ovf        = page_ovf[rd_pg];
    assign bus.pages_used    = pages_used;
endmodule

// File: tb/tb_paged_event_buffer.sv
// Directed bench for paged_event_buffer (PAGE_DEPTH=16, PAGES=4, RD_LATENCY=2).
module tb_paged_event_buffer;
    localparam int DW     = 18;
    localparam int DEPTH  = 16;
    localparam int NPG    = 4;
    localparam int RD_LAT = 2;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    paged_event_buffer_if #(.DATA_WIDTH(DW), .PAGE_DEPTH(DEPTH), .PAGES(NPG)) bus ();

    paged_event_buffer #(
        .DATA_WIDTH(DW), .PAGE_DEPTH(DEPTH), .PAGES(NPG), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [DW-1:0] data, input logic last);
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        bus.wr_last  = last;
        step();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic flush();
        bus.wr_flush = 1'b1;
        step();
        bus.wr_flush = 1'b0;
    endtask

    task automatic release_page();
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
    endtask

    // Single read: no strobe before RD_LAT cycles, strobe and data at RD_LAT
    task automatic read_one(input string tag, input logic [3:0] addr, input logic [DW-1:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        for (int k = 1; k <= RD_LAT; k++) begin
            step();
            bus.rd_en = 1'b0;
            if (k < RD_LAT)
                check({tag, "_early_dv"}, 32'(bus.rd_dvalid), 32'd0);
        end
        check({tag, "_dv"}, 32'(bus.rd_dvalid), 32'd1);
        check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        logic [DW-1:0] burst_exp [3];
        int dv_seen;

        rst_n          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.wr_flush   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;

        // Reset values
        #3;
        check("rst_wr_ready",   32'(bus.wr_ready),      32'd1);
        check("rst_page_valid", 32'(bus.rd_page_valid), 32'd0);
        check("rst_rd_page",    32'(bus.rd_page),       32'd0);
        check("rst_rd_nent",    32'(bus.rd_nent),       32'd0);
        check("rst_rd_ovf",     32'(bus.rd_ovf),        32'd0);
        check("rst_rd_data",    32'(bus.rd_data),       32'd0);
        check("rst_rd_dvalid",  32'(bus.rd_dvalid),     32'd0);
        check("rst_pages_used", 32'(bus.pages_used),    32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Five-beat event into page 0
        for (int i = 1; i <= 5; i++)
            write_beat(DW'(i), i == 5);
        check("ev5_page_valid", 32'(bus.rd_page_valid), 32'd1);
        check("ev5_nent",       32'(bus.rd_nent),       32'd5);
        check("ev5_ovf",        32'(bus.rd_ovf),        32'd0);
        check("ev5_used",       32'(bus.pages_used),    32'd1);
        for (int a = 0; a <= 5; a++)
            read_one($sformatf("ev5_rd%0d", a), 4'(a), (a < 5) ? DW'(a + 1) : '0);

        // Back-to-back reads: one result per cycle after the pipeline fills
        burst_exp[0] = 18'h1;
        burst_exp[1] = 18'h2;
        burst_exp[2] = 18'h3;
        for (int k = 1; k <= 3 + RD_LAT - 1; k++) begin
            bus.rd_en   = (k <= 3);
            bus.rd_addr = 4'(k - 1);
            step();
            if (k < RD_LAT) begin
                check($sformatf("burst%0d_dv", k), 32'(bus.rd_dvalid), 32'd0);
            end else begin
                check($sformatf("burst%0d_dv", k), 32'(bus.rd_dvalid), 32'd1);
                check($sformatf("burst%0d_data", k), 32'(bus.rd_data), 32'(burst_exp[k-RD_LAT]));
            end
        end
        bus.rd_en = 1'b0;

        release_page();
        check("rel0_used",  32'(bus.pages_used),    32'd0);
        check("rel0_valid", 32'(bus.rd_page_valid), 32'd0);
        check("rel0_page",  32'(bus.rd_page),       32'd1);

        // Twenty beats into a 16-entry page: saturate and flag overflow
        for (int i = 1; i <= 20; i++)
            write_beat(DW'(18'h100 + i), i == 20);
        check("ovf_nent", 32'(bus.rd_nent), 32'd16);
        check("ovf_flag", 32'(bus.rd_ovf),  32'd1);
        read_one("ovf_rd15", 4'd15, 18'h110);
        read_one("ovf_rd0",  4'd0,  18'h101);

        // Following page is clean
        write_beat(18'h0AAAA, 1'b1);
        check("pg2_used", 32'(bus.pages_used), 32'd2);
        release_page();
        check("pg2_page", 32'(bus.rd_page), 32'd2);
        check("pg2_ovf",  32'(bus.rd_ovf),  32'd0);
        check("pg2_nent", 32'(bus.rd_nent), 32'd1);
        read_one("pg2_rd0", 4'd0, 18'h0AAAA);

        // Empty flush commits a zero-entry page
        flush();
        check("flush_used", 32'(bus.pages_used), 32'd2);
        release_page();
        check("flush_page", 32'(bus.rd_page), 32'd3);
        check("flush_nent", 32'(bus.rd_nent), 32'd0);
        read_one("flush_rd0", 4'd0, '0);

        // Simultaneous commit and release at pages_used=2
        write_beat(18'h00022, 1'b1);
        check("sim_pre_used", 32'(bus.pages_used), 32'd2);
        bus.wr_valid   = 1'b1;
        bus.wr_data    = 18'h00033;
        bus.wr_last    = 1'b1;
        bus.rd_release = 1'b1;
        step();
        bus.wr_valid   = 1'b0;
        bus.wr_last    = 1'b0;
        bus.rd_release = 1'b0;
        check("sim_used", 32'(bus.pages_used), 32'd2);
        check("sim_page", 32'(bus.rd_page),    32'd0);
        check("sim_nent", 32'(bus.rd_nent),    32'd1);
        read_one("sim_rd0", 4'd0, 18'h00022);

        // Fill to full; a beat and a flush are both refused
        flush();
        flush();
        check("full_used",  32'(bus.pages_used), 32'd4);
        check("full_ready", 32'(bus.wr_ready),   32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 18'h3FFFF;
        bus.wr_last  = 1'b1;
        bus.wr_flush = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_flush = 1'b0;
        check("full_blk_used", 32'(bus.pages_used), 32'd4);
        check("full_blk_nent", 32'(bus.rd_nent),    32'd1);
        read_one("full_blk_rd0", 4'd0, 18'h00022);
        release_page();
        check("unfull_used",  32'(bus.pages_used), 32'd3);
        check("unfull_ready", 32'(bus.wr_ready),   32'd1);
        check("unfull_page",  32'(bus.rd_page),    32'd1);
        // Second half of the simultaneous cycle landed in the next write page
        read_one("sim_wr_rd0", 4'd0, 18'h00033);

        // Reset with two pages committed and a read in flight
        release_page();
        check("prerst_used", 32'(bus.pages_used), 32'd2);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        step();
        bus.rd_en = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mrst_dvalid", 32'(bus.rd_dvalid),     32'd0);
        check("mrst_data",   32'(bus.rd_data),       32'd0);
        check("mrst_used",   32'(bus.pages_used),    32'd0);
        check("mrst_valid",  32'(bus.rd_page_valid), 32'd0);
        check("mrst_page",   32'(bus.rd_page),       32'd0);
        check("mrst_ready",  32'(bus.wr_ready),      32'd1);
        step();
        rst_n = 1'b1;
        // rd_en with no committed page must stay silent too
        bus.rd_en = 1'b1;
        dv_seen   = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.rd_dvalid)
                dv_seen++;
        end
        bus.rd_en = 1'b0;
        check("postrst_no_dv", 32'(dv_seen),         32'd0);
        check("postrst_used",  32'(bus.pages_used),  32'd0);
        check("postrst_nent",  32'(bus.rd_nent),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
